// File: rtl/mem_access_unit_pkg.sv
// Shared constants, FSM encoding and lane-mask helpers for the MEM-stage access unit.
package mem_access_unit_pkg;

  localparam int DATA_BUS     = 32;
  localparam int ADDR_BUS     = 32;
  localparam int MEM_SEL_BUS  = 4;
  localparam int REG_ADDR_BUS = 5;

  typedef enum logic [1:0] {
    MEM_FSM_IDLE = 2'd0,
    MEM_FSM_BUSY = 2'd1,
    MEM_FSM_DONE = 2'd2
  } mem_fsm_e;

  localparam logic [MEM_SEL_BUS-1:0] SEL_B0 = 4'b0001;
  localparam logic [MEM_SEL_BUS-1:0] SEL_B1 = 4'b0010;
  localparam logic [MEM_SEL_BUS-1:0] SEL_B2 = 4'b0100;
  localparam logic [MEM_SEL_BUS-1:0] SEL_B3 = 4'b1000;
  localparam logic [MEM_SEL_BUS-1:0] SEL_H0 = 4'b0011;
  localparam logic [MEM_SEL_BUS-1:0] SEL_H1 = 4'b1100;
  localparam logic [MEM_SEL_BUS-1:0] SEL_W  = 4'b1111;

  function automatic logic [1:0] lowest_lane(input logic [MEM_SEL_BUS-1:0] sel);
    if (sel[0])      return 2'd0;
    else if (sel[1]) return 2'd1;
    else if (sel[2]) return 2'd2;
    else if (sel[3]) return 2'd3;
    else             return 2'd0;
  endfunction

  function automatic logic is_byte_sel(input logic [MEM_SEL_BUS-1:0] sel);
    return (sel == SEL_B0) || (sel == SEL_B1) || (sel == SEL_B2) || (sel == SEL_B3);
  endfunction

  function automatic logic is_half_sel(input logic [MEM_SEL_BUS-1:0] sel);
    return (sel == SEL_H0) || (sel == SEL_H1);
  endfunction

  function automatic logic legal_sel(input logic [MEM_SEL_BUS-1:0] sel);
    return is_byte_sel(sel) || is_half_sel(sel) || (sel == SEL_W);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-RAM request/ready bus between the MEM stage (master) and the data memory (slave).
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic                    ram_en;
  logic [MEM_SEL_BUS-1:0]  ram_write_en;
  logic [ADDR_BUS-1:0]     ram_addr;
  logic [DATA_BUS-1:0]     ram_write_data;
  logic [DATA_BUS-1:0]     ram_read_data;
  logic                    ram_ready;

  modport master (
    output ram_en, ram_write_en, ram_addr, ram_write_data,
    input  ram_read_data, ram_ready
  );

  modport slave (
    input  ram_en, ram_write_en, ram_addr, ram_write_data,
    output ram_read_data, ram_ready
  );
endinterface

// File: rtl/mem_access_unit_load_data_align.sv
// Load alignment: moves the selected byte lanes down to bit 0 and sign/zero extends by access size.
module load_data_align
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_BUS-1:0]    data,
  input  logic [MEM_SEL_BUS-1:0] sel,
  input  logic                   sign_ext,
  output logic [DATA_BUS-1:0]    data_out
);

  logic [DATA_BUS-1:0] shifted;

  always_comb begin
    shifted = data >> {lowest_lane(sel), 3'b000};
    if (is_byte_sel(sel))
      data_out = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
    else if (is_half_sel(sel))
      data_out = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
    else
      data_out = shifted;
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one RAM transaction per instruction, load alignment, MEM/WB forwarding.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_current_stage,
  input  logic                    mem_read_flag_in,
  input  logic                    mem_write_flag_in,
  input  logic                    mem_sign_ext_flag_in,
  input  logic [MEM_SEL_BUS-1:0]  mem_sel_in,
  input  logic [DATA_BUS-1:0]     mem_write_data_in,
  input  logic [DATA_BUS-1:0]     result_in,
  input  logic                    reg_write_en_in,
  input  logic [REG_ADDR_BUS-1:0] reg_write_addr_in,
  input  logic [ADDR_BUS-1:0]     current_pc_addr_in,
  mem_access_unit_if.master       bus,
  output logic                    stall_request,
  output logic [DATA_BUS-1:0]     result_out,
  output logic                    reg_write_en_out,
  output logic [REG_ADDR_BUS-1:0] reg_write_addr_out,
  output logic [ADDR_BUS-1:0]     current_pc_addr_out,
  output logic                    misalign_out
);

  mem_fsm_e            state, state_nxt;
  logic [DATA_BUS-1:0] cap_q;
  logic                capture;
  logic                mem_op, misalign, access, in_flight;
  logic [DATA_BUS-1:0] align_src, load_data;

  assign mem_op = mem_read_flag_in | mem_write_flag_in;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = mem_op &
                    (!legal_sel(mem_sel_in) || (lowest_lane(mem_sel_in) != result_in[1:0]));
`else
  assign misalign = 1'b0;
`endif

  assign misalign_out = misalign;
  assign access       = mem_op & ~misalign;
  // DONE suppresses the request so a held instruction never re-issues.
  assign in_flight    = access & (state != MEM_FSM_DONE);

  // Reset gates the request combinationally so an outstanding access drops at once.
  assign bus.ram_en         = rst & in_flight;
  assign bus.ram_write_en   = (rst & in_flight & mem_write_flag_in) ? mem_sel_in : '0;
  assign bus.ram_addr       = {result_in[ADDR_BUS-1:2], 2'b00};
  assign bus.ram_write_data = mem_write_data_in;

  assign stall_request = in_flight & ~bus.ram_ready;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      MEM_FSM_IDLE: begin
        if (access && bus.ram_ready) begin
          capture = mem_read_flag_in;
          if (stall_current_stage) state_nxt = MEM_FSM_DONE;
        end else if (access) begin
          state_nxt = MEM_FSM_BUSY;
        end
      end
      MEM_FSM_BUSY: begin
        if (!access) begin
          state_nxt = MEM_FSM_IDLE;
        end else if (bus.ram_ready) begin
          capture   = mem_read_flag_in;
          state_nxt = stall_current_stage ? MEM_FSM_DONE : MEM_FSM_IDLE;
        end
      end
      MEM_FSM_DONE: begin
        if (!stall_current_stage) state_nxt = MEM_FSM_IDLE;
      end
      default: state_nxt = MEM_FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MEM_FSM_IDLE;
      cap_q <= '0;
    end else begin
      state <= state_nxt;
      if (capture) cap_q <= bus.ram_read_data;
    end
  end

  // Raw word is captured; alignment reuses the held sel/sign inputs while in DONE.
  assign align_src = (state == MEM_FSM_DONE) ? cap_q : bus.ram_read_data;

  load_data_align u_align (
    .data     (align_src),
    .sel      (mem_sel_in),
    .sign_ext (mem_sign_ext_flag_in),
    .data_out (load_data)
  );

  assign result_out          = (mem_read_flag_in && !misalign) ? load_data : result_in;
  assign reg_write_en_out    = reg_write_en_in & ~stall_request & ~misalign;
  assign reg_write_addr_out  = reg_write_addr_in;
  assign current_pc_addr_out = current_pc_addr_in;

endmodule
